// File: rtl/spi_counter_rx.sv
// spi_counter_rx
//   SPI (mode 0) slave receiver for the counter-to-display link. The sender
//   transmits a 16-bit count as two bytes, LSB byte first, each byte MSB-first.
//   This block reassembles the pair and presents it with a one-cycle strobe.
//   It also flags malformed frames: partial bytes and a missing MSB byte.
//
// Ports
//   clk      in   system clock (>= 4x sclk)
//   reset    in   asynchronous, active-high reset
//   sclk     in   SPI clock from master, asynchronous to clk
//   mosi     in   SPI data from master
//   cs_n     in   SPI chip select, active-low
//   o_data   out  last complete value {MSB byte, LSB byte}
//   o_valid  out  one-cycle pulse when o_data updates
//   o_err    out  one-cycle pulse on a partial byte or an MSB timeout
//   o_busy   out  high while an LSB byte is held and the MSB is pending
module spi_counter_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, RX_MSB} state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, mosi_s, cs_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    logic sclk_rise, cs_rise, accept;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // A rise coinciding with cs_n going high still counts: cs was low on the
    // previous cycle, so the bit is taken before the deselect is processed.
    assign accept    = sclk_rise & ~(cs_s & cs_prev_q);

    // ------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       abort_q, abort_d;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        abort_d     = 1'b0;
        if (accept) begin
            shift_d = {shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d   = 3'd0;
                byte_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
        // Deselect mid-byte: drop the partial byte and abort the pair.
        if (cs_rise && bit_cnt_d != 3'd0) begin
            abort_d   = 1'b1;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            abort_q     <= abort_d;
        end
    end

    // ------------------------------------------------------------------
    // Pair tracking FSM. shift_q still holds the finished byte while
    // byte_done_q is high: the next accepted rise needs sclk to fall and
    // rise again, which takes at least two clk cycles.
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [7:0]      lsb_q, lsb_d;
    logic [15:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        lsb_d   = lsb_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (byte_done_q) begin
                    lsb_d   = shift_q;
                    state_d = RX_MSB;
                    tmo_d   = '0;
                end else if (abort_q) begin
                    err_d = 1'b1;
                end
            end
            RX_MSB: begin
                // Completion takes priority over timeout.
                if (byte_done_q) begin
                    data_d  = {shift_q, lsb_q};
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (abort_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lsb_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            lsb_q   <= lsb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q == RX_MSB);

endmodule

// File: tb/tb_spi_counter_rx.sv
// Testbench for spi_counter_rx: directed scenarios plus randomized frames
// checked against a pair-level model (expected value, valid count, err count).
module tb_spi_counter_rx;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic [15:0] o_data;
    logic        o_valid, o_err, o_busy;

    spi_counter_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .o_data(o_data), .o_valid(o_valid), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    int nv = 0, ne = 0, nboth = 0;
    logic [15:0] last_v = '0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (o_valid) begin nv++; last_v = o_data; end
        if (o_err) ne++;
        if (o_valid && o_err) nboth++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift out the top n bits of b, MSB first, with h clk per sclk phase.
    task automatic bits(input logic [7:0] b, input int n, input int h);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            cyc(h);
            sclk = 1'b1;
            cyc(h);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo(input int h); cs_n = 1'b0; cyc(h); endtask
    task automatic cs_hi(input int h); cyc(h); cs_n = 1'b1; cyc(8); endtask

    task automatic pair1(input logic [7:0] l, input logic [7:0] m, input int h);
        cs_lo(h); bits(l, 8, h); bits(m, 8, h); cs_hi(h);
    endtask

    // model state
    logic [15:0] ed;
    int ev, ee;

    task automatic model_chk(input string tag);
        chk({tag, "_nv"}, nv, ev);
        chk({tag, "_ne"}, ne, ee);
        chk({tag, "_data"}, o_data, ed);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        ed = '0; ev = 0; ee = 0;
        cyc(3);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_busy", o_busy, 0);
        reset = 1'b0;
        cyc(3);

        // 1. single frame
        pair1(8'h34, 8'h12, 3);
        ed = 16'h1234; ev++;
        model_chk("t1");
        chk("t1_last", last_v, 16'h1234);

        // 2. split frames, busy only between bytes
        cs_lo(3); bits(8'hFF, 8, 3); cs_hi(3);
        chk("t2_busy_mid", o_busy, 1);
        cs_lo(3); bits(8'h00, 8, 3); cs_hi(3);
        ed = 16'h00FF; ev++;
        model_chk("t2");

        // 3. partial LSB then a good pair
        cs_lo(3); bits(8'hA5, 5, 3); cs_hi(3);
        ee++;
        model_chk("t3a");
        pair1(8'hAB, 8'hCD, 3);
        ed = 16'hCDAB; ev++;
        model_chk("t3b");

        // 4. timeout after LSB
        cs_lo(3); bits(8'h55, 8, 3); cs_hi(3);
        cyc(40);
        chk("t4_busy_early", o_busy, 1);
        chk("t4_ne_early", ne, ee);
        cyc(40);
        ee++;
        model_chk("t4a");
        pair1(8'h01, 8'h02, 3);
        ed = 16'h0201; ev++;
        model_chk("t4b");

        // 5. reset mid MSB byte
        cs_lo(3); bits(8'h99, 8, 3); bits(8'h88, 3, 3);
        reset = 1'b1;
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cyc(1);
        chk("t5_rst_data", o_data, 0);
        chk("t5_rst_busy", o_busy, 0);
        cyc(2);
        reset = 1'b0;
        cyc(4);
        ed = '0;
        model_chk("t5a");
        pair1(8'h78, 8'h56, 3);
        ed = 16'h5678; ev++;
        model_chk("t5b");

        // 6. sclk activity while deselected is ignored
        bits(8'hF0, 8, 2); bits(8'h0F, 8, 2); bits(8'hFF, 4, 2);
        cyc(6);
        model_chk("t6");
        cs_lo(3); bits(8'h11, 8, 3); cs_hi(3);
        chk("t6_busy_after_lsb", o_busy, 1);
        cs_lo(3); bits(8'h22, 8, 3); cs_hi(3);
        ed = 16'h2211; ev++;
        model_chk("t6b");

        // 8th rise and cs rise together: byte counts, no error
        cs_lo(3); bits(8'h3C, 8, 3); bits(8'h5A, 7, 3);
        mosi = 1'b0; cyc(3);
        sclk = 1'b1; cs_n = 1'b1;
        cyc(3); sclk = 1'b0; cyc(8);
        ed = 16'h5A3C; ev++;
        model_chk("simul");

        // Extra byte after MSB starts a new pair
        cs_lo(3); bits(8'hC3, 8, 3); bits(8'h7E, 8, 3); bits(8'h42, 8, 3); cs_hi(3);
        ed = 16'h7EC3; ev++;
        chk("extra_busy", o_busy, 1);
        cs_lo(3); bits(8'h24, 8, 3); cs_hi(3);
        ed = 16'h2442; ev++;
        model_chk("extra");

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            logic [7:0] l, m;
            int mode, h, k;
            l = 8'($urandom); m = 8'($urandom);
            mode = $urandom_range(0, 2);
            h = $urandom_range(2, 5);
            if (mode == 0) begin
                pair1(l, m, h);
                ed = {m, l}; ev++;
            end else if (mode == 1) begin
                cs_lo(h); bits(l, 8, h); cs_hi(h);
                cyc($urandom_range(0, 20));
                cs_lo(h); bits(m, 8, h); cs_hi(h);
                ed = {m, l}; ev++;
            end else begin
                k = $urandom_range(1, 7);
                if ($urandom_range(0, 1) == 1) begin
                    cs_lo(h); bits(l, 8, h); cs_hi(h);
                end
                cs_lo(h); bits(m, k, h); cs_hi(h);
                ee++;
            end
            model_chk("rnd");
        end

        chk("never_both", nboth, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
